dmem_port_arbiter: RTL and testbench

- Shares the single 16-bit-address, byte-addressed data memory between two requesters: port 0 (CPU load/store unit) and port 1 (loader/DMA).
- Sequences sub-word stores as read-modify-write, because the memory writes only full 4-byte words at any byte address.
- Sign/zero-extends sub-word loads.
- Sits between the requesters and the data memory's rden/wren/rdaddress/wraddress/write_data/read_data interface.

---
 rtl/dmem_port_arbiter_if.sv | 38 +++
 rtl/dmem_port_arbiter.sv | 134 +++++++++++++
 tb/tb_dmem_port_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_port_arbiter_if.sv
// Requester-side and memory-side bundles for the shared data-memory arbiter.
// The master modport is the side that starts an access.
interface dmem_req_if #(
    parameter int AW = 16,
    parameter int DW = 32
);
    logic          req;
    logic          we;
    logic [1:0]    size;
    logic          ld_unsigned;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          done;
    logic          err;
    logic [DW-1:0] rdata;

    modport master (output req, we, size, ld_unsigned, addr, wdata,
                    input  done, err, rdata);
    modport slave  (input  req, we, size, ld_unsigned, addr, wdata,
                    output done, err, rdata);
endinterface

interface dmem_mem_if #(
    parameter int AW = 16,
    parameter int DW = 32
);
    logic          rden;
    logic          wren;
    logic [AW-1:0] rdaddress;
    logic [AW-1:0] wraddress;
    logic [DW-1:0] write_data;
    logic [DW-1:0] read_data;

    modport master (output rden, wren, rdaddress, wraddress, write_data,
                    input  read_data);
    modport slave  (input  rden, wren, rdaddress, wraddress, write_data,
                    output read_data);
endinterface

// File: rtl/dmem_port_arbiter.sv
// Two-port round-robin arbiter in front of a word-write-only data memory.
// Sub-word stores become read-modify-write; sub-word loads are extended here.
module dmem_port_arbiter #(
    parameter int AW = 16,
    parameter int DW = 32
) (
    input  logic       clk,
    input  logic       rst,
    dmem_req_if.slave  p0,
    dmem_req_if.slave  p1,
    dmem_mem_if.master mem
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t        state, state_nxt;
    logic          last_gnt;
    logic          gnt, gnt_vld;
    logic          sel_we, sel_uns, sel_err;
    logic [1:0]    sel_size;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    logic          lat_port, lat_we, lat_uns, lat_err;
    logic [1:0]    lat_size;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata, cap, rdata0, rdata1;

    // Access is rejected when the size is illegal or its last byte runs off the top.
    function automatic logic bad_access(input logic [1:0] sz, input logic [AW-1:0] a);
        logic [AW:0] last;
        last = {1'b0, a};
        case (sz)
            2'b00:   last = {1'b0, a};
            2'b01:   last = last + (AW+1)'(1);
            2'b10:   last = last + (AW+1)'(3);
            default: last = '1;
        endcase
        return last[AW];
    endfunction

    function automatic logic [DW-1:0] load_ext(input logic [DW-1:0] w, input logic [1:0] sz,
                                               input logic zx);
        case (sz)
            2'b00:   return {{(DW-8){w[7] & ~zx}}, w[7:0]};
            2'b01:   return {{(DW-16){w[15] & ~zx}}, w[15:0]};
            default: return w;
        endcase
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                            input logic [1:0] sz);
        case (sz)
            2'b00:   return {old[DW-1:8], nw[7:0]};
            2'b01:   return {old[DW-1:16], nw[15:0]};
            default: return nw;
        endcase
    endfunction

    always_comb begin
        gnt_vld   = p0.req | p1.req;
        gnt       = (p0.req & p1.req) ? ~last_gnt : p1.req;
        sel_we    = gnt ? p1.we          : p0.we;
        sel_size  = gnt ? p1.size        : p0.size;
        sel_uns   = gnt ? p1.ld_unsigned : p0.ld_unsigned;
        sel_addr  = gnt ? p1.addr        : p0.addr;
        sel_wdata = gnt ? p1.wdata       : p0.wdata;
        sel_err   = bad_access(sel_size, sel_addr);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (gnt_vld) begin
                if (sel_err)                            state_nxt = RESP;
                else if (!sel_we || sel_size != 2'b10)  state_nxt = RD;
                else                                    state_nxt = WR;
            end
            RD:      state_nxt = lat_we ? WR : RESP;
            WR:      state_nxt = RESP;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
        end else begin
            state <= state_nxt;
            if (state == IDLE && gnt_vld) last_gnt <= gnt;
        end
    end

    // Request fields are latched at grant; the load result lands at the end of RD.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_addr <= '0;
            rdata0   <= '0;
            rdata1   <= '0;
        end else begin
            if (state == IDLE && gnt_vld) begin
                lat_port  <= gnt;
                lat_we    <= sel_we;
                lat_size  <= sel_size;
                lat_uns   <= sel_uns;
                lat_addr  <= sel_addr;
                lat_wdata <= sel_wdata;
                lat_err   <= sel_err;
            end
            if (state == RD) begin
                cap <= mem.read_data;
                if (!lat_we && !lat_port) rdata0 <= load_ext(mem.read_data, lat_size, lat_uns);
                if (!lat_we &&  lat_port) rdata1 <= load_ext(mem.read_data, lat_size, lat_uns);
            end
        end
    end

    // A reset in RD or WR suppresses the access in that very cycle.
    always_comb begin
        mem.rden       = (state == RD) & ~rst;
        mem.wren       = (state == WR) & ~rst;
        mem.rdaddress  = lat_addr;
        mem.wraddress  = lat_addr;
        mem.write_data = (state == WR) ? merge(cap, lat_wdata, lat_size) : '0;
        p0.done        = (state == RESP) & ~lat_port & ~rst;
        p1.done        = (state == RESP) &  lat_port & ~rst;
        p0.err         = p0.done & lat_err;
        p1.err         = p1.done & lat_err;
        p0.rdata       = rdata0;
        p1.rdata       = rdata1;
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Randomized and directed bench for dmem_port_arbiter with a byte-array memory
// and a byte-level reference model of loads, stores and access errors.
module tb_dmem_port_arbiter;
    localparam int AW = 16;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dmem_req_if #(.AW(AW), .DW(DW)) p0_if ();
    dmem_req_if #(.AW(AW), .DW(DW)) p1_if ();
    dmem_mem_if #(.AW(AW), .DW(DW)) m_if ();

    dmem_port_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .p0  (p0_if),
        .p1  (p1_if),
        .mem (m_if)
    );

    logic [7:0]  ram     [0:65535];
    logic [7:0]  ref_mem [0:65535];
    logic        pk_en;
    logic [15:0] pk_addr;
    logic [31:0] pk_data;
    int          n_cmp = 0;
    int          n_bad = 0;

    always @(posedge clk) begin
        if (m_if.wren)
            for (int i = 0; i < 4; i++) ram[m_if.wraddress + 16'(i)] <= m_if.write_data[8*i +: 8];
        if (pk_en)
            for (int i = 0; i < 4; i++) ram[pk_addr + 16'(i)] <= pk_data[8*i +: 8];
    end

    assign m_if.read_data = {ram[m_if.rdaddress + 16'd3], ram[m_if.rdaddress + 16'd2],
                             ram[m_if.rdaddress + 16'd1], ram[m_if.rdaddress]};

    function automatic logic [31:0] peek(input int a);
        logic [15:0] b;
        b = 16'(a);
        return {ram[b + 16'd3], ram[b + 16'd2], ram[b + 16'd1], ram[b]};
    endfunction

    function automatic int nbytes(input int sz);
        return (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
    endfunction

    function automatic bit ref_err(input int sz, input int a);
        return (sz == 3) || (a + nbytes(sz) > 65536);
    endfunction

    function automatic logic [31:0] ref_load(input int a, input int sz, input bit uns);
        longint v;
        int     n;
        n = nbytes(sz);
        v = 0;
        for (int i = 0; i < n; i++) v += longint'(ref_mem[(a + i) & 16'hFFFF]) << (8 * i);
        if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
        return 32'(v);
    endfunction

    task automatic ref_store(input int a, input int sz, input logic [31:0] wd);
        for (int i = 0; i < nbytes(sz); i++) ref_mem[(a + i) & 16'hFFFF] = wd[8*i +: 8];
    endtask

    task automatic init_word(input int a, input logic [31:0] w);
        @(negedge clk);
        pk_en = 1'b1; pk_addr = 16'(a); pk_data = w;
        @(negedge clk);
        pk_en = 1'b0;
        for (int i = 0; i < 4; i++) ref_mem[(a + i) & 16'hFFFF] = w[8*i +: 8];
    endtask

    task automatic set_req(input int p, input bit we, input int sz, input bit uns, input int a,
                           input logic [31:0] wd);
        if (p == 0) begin
            p0_if.req = 1'b1; p0_if.we = we; p0_if.size = 2'(sz); p0_if.ld_unsigned = uns;
            p0_if.addr = 16'(a); p0_if.wdata = wd;
        end else begin
            p1_if.req = 1'b1; p1_if.we = we; p1_if.size = 2'(sz); p1_if.ld_unsigned = uns;
            p1_if.addr = 16'(a); p1_if.wdata = wd;
        end
    endtask

    task automatic clr_req();
        p0_if.req = 1'b0; p0_if.we = 1'b0; p0_if.size = 2'b00; p0_if.ld_unsigned = 1'b0;
        p0_if.addr = '0;  p0_if.wdata = '0;
        p1_if.req = 1'b0; p1_if.we = 1'b0; p1_if.size = 2'b00; p1_if.ld_unsigned = 1'b0;
        p1_if.addr = '0;  p1_if.wdata = '0;
    endtask

    // Issues one request and reports latency (negedges after the grant cycle), result and bus activity.
    task automatic do_txn(input int p, input bit we, input int sz, input bit uns, input int a,
                          input logic [31:0] wd, output int lat, output logic [31:0] rd,
                          output logic e, output int nrd, output int nwr, output int nbus,
                          output logic [31:0] wdat);
        @(negedge clk);
        set_req(p, we, sz, uns, a, wd);
        lat = -1; rd = 'x; e = 1'bx; nrd = 0; nwr = 0; nbus = 0; wdat = '0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (m_if.rden) nrd++;
            if (m_if.wren) begin nwr++; wdat = m_if.write_data; end
            if (m_if.rden && m_if.wren) nbus++;
            if ((p == 0) ? p1_if.done : p0_if.done) nbus++;
            if ((p == 0) ? p0_if.done : p1_if.done) begin
                lat = k;
                rd  = (p == 0) ? p0_if.rdata : p1_if.rdata;
                e   = (p == 0) ? p0_if.err : p1_if.err;
                break;
            end
        end
        clr_req();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        clr_req();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        n_cmp++; if ({p0_if.done, p0_if.err, p1_if.done, p1_if.err, m_if.rden, m_if.wren} !== 6'b0) begin
            n_bad++; $display("FAIL rst_ctrl got=%b exp=000000",
                {p0_if.done, p0_if.err, p1_if.done, p1_if.err, m_if.rden, m_if.wren}); end
        n_cmp++; if ({p0_if.rdata, p1_if.rdata} !== 64'h0) begin
            n_bad++; $display("FAIL rst_rdata got=%h/%h exp=0", p0_if.rdata, p1_if.rdata); end
        n_cmp++; if ({m_if.rdaddress, m_if.wraddress} !== 32'h0) begin
            n_bad++; $display("FAIL rst_addr got=%h/%h exp=0", m_if.rdaddress, m_if.wraddress); end
        n_cmp++; if (m_if.write_data !== 32'h0) begin
            n_bad++; $display("FAIL rst_wdata got=%h exp=0", m_if.write_data); end
    endtask

    task automatic test_word();
        int lat, nrd, nwr, nbus; logic [31:0] rd, wdat; logic e;
        do_txn(0, 1'b1, 2, 1'b0, 'h0100, 32'hDEADBEEF, lat, rd, e, nrd, nwr, nbus, wdat);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL wst_lat got=%0d exp=2", lat); end
        n_cmp++; if ({e, nrd[1:0], nwr[1:0], nbus[1:0]} !== 7'b0_00_01_00) begin
            n_bad++; $display("FAIL wst_bus got err=%b rd=%0d wr=%0d bad=%0d exp 0/0/1/0", e, nrd, nwr, nbus); end
        n_cmp++; if (peek('h0100) !== 32'hDEADBEEF) begin
            n_bad++; $display("FAIL wst_mem got=%h exp=deadbeef", peek('h0100)); end
        do_txn(0, 1'b0, 2, 1'b0, 'h0100, 32'h0, lat, rd, e, nrd, nwr, nbus, wdat);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL wld_lat got=%0d exp=2", lat); end
        n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL wld_data got=%h exp=deadbeef", rd); end
        n_cmp++; if ({nrd[1:0], nwr[1:0]} !== 4'b01_00) begin
            n_bad++; $display("FAIL wld_bus got rd=%0d wr=%0d exp 1/0", nrd, nwr); end
    endtask

    task automatic test_subword();
        int lat, nrd, nwr, nbus; logic [31:0] rd, wdat; logic e;
        init_word('h0200, 32'h11223344);
        do_txn(1, 1'b1, 0, 1'b0, 'h0200, 32'hFFFFFFAB, lat, rd, e, nrd, nwr, nbus, wdat);
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL bst_lat got=%0d exp=3", lat); end
        n_cmp++; if ({nrd[1:0], nwr[1:0], nbus[1:0]} !== 6'b01_01_00) begin
            n_bad++; $display("FAIL bst_bus got rd=%0d wr=%0d bad=%0d exp 1/1/0", nrd, nwr, nbus); end
        n_cmp++; if (wdat !== 32'h112233AB) begin n_bad++; $display("FAIL bst_wword got=%h exp=112233ab", wdat); end
        do_txn(1, 1'b0, 0, 1'b0, 'h0200, 32'h0, lat, rd, e, nrd, nwr, nbus, wdat);
        n_cmp++; if (rd !== 32'hFFFFFFAB) begin n_bad++; $display("FAIL bld_s got=%h exp=ffffffab", rd); end
        do_txn(1, 1'b0, 0, 1'b1, 'h0200, 32'h0, lat, rd, e, nrd, nwr, nbus, wdat);
        n_cmp++; if (rd !== 32'h000000AB) begin n_bad++; $display("FAIL bld_u got=%h exp=000000ab", rd); end
        do_txn(0, 1'b0, 1, 1'b0, 'h0201, 32'h0, lat, rd, e, nrd, nwr, nbus, wdat);
        n_cmp++; if (rd !== 32'h00002233) begin n_bad++; $display("FAIL hld_s got=%h exp=00002233", rd); end
        do_txn(0, 1'b1, 1, 1'b0, 'h0201, 32'hABCD8001, lat, rd, e, nrd, nwr, nbus, wdat);
        n_cmp++; if (peek('h0200) !== 32'h118001AB) begin
            n_bad++; $display("FAIL hst_mem got=%h exp=118001ab", peek('h0200)); end
        do_txn(0, 1'b0, 1, 1'b0, 'h0201, 32'h0, lat, rd, e, nrd, nwr, nbus, wdat);
        n_cmp++; if (rd !== 32'hFFFF8001) begin n_bad++; $display("FAIL hld_neg got=%h exp=ffff8001", rd); end
    endtask

    task automatic test_error();
        int lat, nrd, nwr, nbus; logic [31:0] rd, wdat; logic e;
        do_txn(0, 1'b0, 2, 1'b0, 'hFFFD, 32'h0, lat, rd, e, nrd, nwr, nbus, wdat);
        n_cmp++; if ({lat[3:0], e} !== 5'b0001_1) begin
            n_bad++; $display("FAIL err_top got lat=%0d err=%b exp lat=1 err=1", lat, e); end
        n_cmp++; if ({nrd[1:0], nwr[1:0]} !== 4'b0) begin
            n_bad++; $display("FAIL err_top_bus got rd=%0d wr=%0d exp 0/0", nrd, nwr); end
        do_txn(1, 1'b1, 3, 1'b0, 'h0000, 32'h12345678, lat, rd, e, nrd, nwr, nbus, wdat);
        n_cmp++; if ({lat[3:0], e} !== 5'b0001_1) begin
            n_bad++; $display("FAIL err_size got lat=%0d err=%b exp lat=1 err=1", lat, e); end
        n_cmp++; if ({nrd[1:0], nwr[1:0]} !== 4'b0) begin
            n_bad++; $display("FAIL err_size_bus got rd=%0d wr=%0d exp 0/0", nrd, nwr); end
    endtask

    task automatic test_round_robin();
        int got;
        apply_reset();
        @(negedge clk);
        set_req(0, 1'b0, 2, 1'b0, 'h0100, 32'h0);
        set_req(1, 1'b0, 2, 1'b0, 'h0200, 32'h0);
        for (int t = 0; t < 8; t++) begin
            got = -1;
            for (int k = 0; k < 8 && got < 0; k++) begin
                @(negedge clk);
                if (p0_if.done && p1_if.done) got = 2;
                else if (p0_if.done) got = 0;
                else if (p1_if.done) got = 1;
            end
            n_cmp++; if (got !== t % 2) begin
                n_bad++; $display("FAIL rr_order txn=%0d got port=%0d exp=%0d", t, got, t % 2); end
            if (got == 0) begin
                n_cmp++; if (p0_if.rdata !== 32'hDEADBEEF) begin
                    n_bad++; $display("FAIL rr_data0 got=%h exp=deadbeef", p0_if.rdata); end
            end else if (got == 1) begin
                n_cmp++; if (p1_if.rdata !== 32'h118001AB) begin
                    n_bad++; $display("FAIL rr_data1 got=%h exp=118001ab", p1_if.rdata); end
            end
        end
        clr_req();
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int lat, nrd, nwr, nbus, seen; logic [31:0] rd, wdat; logic e;
        init_word('h0300, 32'h55667788);
        @(negedge clk);
        set_req(0, 1'b1, 0, 1'b0, 'h0300, 32'h00000099);
        @(negedge clk);
        n_cmp++; if (m_if.rden !== 1'b1) begin n_bad++; $display("FAIL rmid_rd got=%b exp=1", m_if.rden); end
        rst = 1'b1;
        clr_req();
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            rst = 1'b0;
            if (p0_if.done || p1_if.done || m_if.wren) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL rmid_quiet got=%0d events exp=0", seen); end
        n_cmp++; if (peek('h0300) !== 32'h55667788) begin
            n_bad++; $display("FAIL rmid_mem got=%h exp=55667788", peek('h0300)); end
        do_txn(1, 1'b0, 2, 1'b0, 'h0300, 32'h0, lat, rd, e, nrd, nwr, nbus, wdat);
        n_cmp++; if ({lat[3:0], rd} !== {4'd2, 32'h55667788}) begin
            n_bad++; $display("FAIL rmid_next got lat=%0d data=%h exp lat=2 data=55667788", lat, rd); end
    endtask

    task automatic test_random();
        int lat, nrd, nwr, nbus, p, sz, a, r, exp_lat, exp_rd, exp_wr;
        logic [31:0] rd, wdat, wd; logic e; bit we, uns, xe;
        for (int i = 0; i < 6; i++) init_word('h0400 + 4 * i, $urandom);
        init_word('hFFF8, $urandom);
        init_word('hFFFC, $urandom);
        init_word('h0000, $urandom);
        for (int t = 0; t < 40; t++) begin
            p   = int'($urandom_range(0, 1));
            we  = 1'($urandom_range(0, 1));
            uns = 1'($urandom_range(0, 1));
            r   = int'($urandom_range(0, 9));
            sz  = (r < 3) ? 0 : (r < 6) ? 1 : (r < 9) ? 2 : 3;
            a   = ($urandom_range(0, 3) == 0) ? 'hFFF8 + int'($urandom_range(0, 7))
                                               : 'h0400 + int'($urandom_range(0, 19));
            wd  = $urandom;
            xe  = ref_err(sz, a);
            exp_lat = xe ? 1 : (!we || sz == 2) ? 2 : 3;
            exp_rd  = (xe || (we && sz == 2)) ? 0 : 1;
            exp_wr  = (!xe && we) ? 1 : 0;
            do_txn(p, we, sz, uns, a, wd, lat, rd, e, nrd, nwr, nbus, wdat);
            n_cmp++; if ({e, lat, nrd, nwr, nbus} !== {xe, exp_lat, exp_rd, exp_wr, 0}) begin
                n_bad++; $display("FAIL rnd_ctrl t=%0d a=%h sz=%0d we=%b got err=%b lat=%0d rd=%0d wr=%0d bad=%0d exp err=%b lat=%0d rd=%0d wr=%0d",
                    t, a, sz, we, e, lat, nrd, nwr, nbus, xe, exp_lat, exp_rd, exp_wr); end
            if (!xe && !we) begin
                n_cmp++; if (rd !== ref_load(a, sz, uns)) begin
                    n_bad++; $display("FAIL rnd_load t=%0d a=%h sz=%0d uns=%b got=%h exp=%h",
                        t, a, sz, uns, rd, ref_load(a, sz, uns)); end
            end
            if (!xe && we) begin
                ref_store(a, sz, wd);
                n_cmp++; if (peek(a) !== ref_load(a, 2, 1'b1)) begin
                    n_bad++; $display("FAIL rnd_store t=%0d a=%h sz=%0d got=%h exp=%h",
                        t, a, sz, peek(a), ref_load(a, 2, 1'b1)); end
            end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        pk_en = 1'b0; pk_addr = '0; pk_data = '0;
        clr_req();
        test_reset();
        test_word();
        test_subword();
        test_error();
        test_round_robin();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
